// File: rtl/baud_rate_generator.sv
// ---------------------------------------------------------------------------
// baud_rate_generator
//
// Programmable baud-clock divider for the UART. Divides the 576 kHz system
// clock by 60, 30, 15 or 10 to give a square-wave baud_clk at 9600, 19200,
// 38400 or 57600 Hz. It also reports the active rate as a number.
//
// Parameters:
//   CLK_HZ    - system clock frequency (informational only)
//   CNT_W     - divider counter width, must hold 59
//
// Ports:
//   clk       - system clock, rising-edge active
//   reset     - asynchronous, active-high reset
//   sel[1:0]  - rate select: 00=9600, 01=19200, 10=38400, 11=57600
//   baud_clk  - registered square-wave baud clock
//   baud_rate - numeric baud rate currently in effect (from latched select)
//   baud_tick - one-cycle pulse on each period wrap (only with the
//               BAUD_GEN_TICK_EN macro defined)
//
// Optional feature macro: BAUD_GEN_TICK_EN
// ---------------------------------------------------------------------------
module baud_rate_generator #(
    parameter int CLK_HZ = 576000,
    parameter int CNT_W  = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  sel,
    output logic        baud_clk,
    output logic [16:0] baud_rate
`ifdef BAUD_GEN_TICK_EN
    ,
    output logic        baud_tick
`endif
);

    // Elaboration-time sanity checks on the configuration.
    if (CNT_W < 6) begin : g_cnt_w_too_small
        $error("CNT_W must be at least 6 to hold a count of 59");
    end
    if (CLK_HZ <= 0) begin : g_clk_hz_invalid
        $error("CLK_HZ must be positive");
    end

    logic [1:0]       sel_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] lim_m1;   // L-1: last count of the period
    logic [CNT_W-1:0] half;     // floor(L/2): count at which baud_clk goes high

    // Divide limit and reported rate both follow the latched select, so a
    // select change only takes effect together with the restart.
    always_comb begin
        lim_m1    = CNT_W'(59);
        half      = CNT_W'(30);
        baud_rate = 17'd9600;
        case (sel_q)
            2'b00: begin lim_m1 = CNT_W'(59); half = CNT_W'(30); baud_rate = 17'd9600;  end
            2'b01: begin lim_m1 = CNT_W'(29); half = CNT_W'(15); baud_rate = 17'd19200; end
            2'b10: begin lim_m1 = CNT_W'(14); half = CNT_W'(7);  baud_rate = 17'd38400; end
            2'b11: begin lim_m1 = CNT_W'(9);  half = CNT_W'(5);  baud_rate = 17'd57600; end
            default: begin lim_m1 = CNT_W'(59); half = CNT_W'(30); baud_rate = 17'd9600; end
        endcase
    end

    assign cnt_inc = cnt + CNT_W'(1);

    // Rate-change restart has priority over the wrap; both leave cnt at 0
    // and baud_clk low, so a coincident change and wrap look the same.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q    <= 2'b00;
            cnt      <= '0;
            baud_clk <= 1'b0;
        end else if (sel != sel_q) begin
            sel_q    <= sel;
            cnt      <= '0;
            baud_clk <= 1'b0;
        end else if (cnt == lim_m1) begin
            cnt      <= '0;
            baud_clk <= 1'b0;
        end else begin
            cnt      <= cnt_inc;
            baud_clk <= (cnt_inc >= half);
        end
    end

`ifdef BAUD_GEN_TICK_EN
    // Wrap only counts when no restart is happening on the same edge, so
    // the tick never fires on a rate change.
    logic wrap;
    assign wrap = (sel == sel_q) && (cnt == lim_m1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_tick <= 1'b0;
        end else begin
            baud_tick <= wrap;
        end
    end
`endif

endmodule

// File: tb/tb_baud_rate_generator.sv
// ---------------------------------------------------------------------------
// tb_baud_rate_generator
//
// Self-checking bench for baud_rate_generator. The driver issues one clock
// edge of stimulus at a time and pushes the expected outputs for that edge
// into exp_q; an independent monitor pops and compares on the falling edge.
// Expected values come from a waveform model: position within the current
// period, limit table and rate = CLK_HZ / L.
// ---------------------------------------------------------------------------
module tb_baud_rate_generator;

  localparam int CLK_HZ = 576000;
  localparam int W      = 19;     // {tick, baud_clk, baud_rate[16:0]}

  // -------------------------------------------------------------------------
  // clock / reset block
  // -------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sel;
  logic        baud_clk;
  logic [16:0] baud_rate;
  logic        baud_tick;

  always #5 clk = ~clk;

  baud_rate_generator #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .baud_clk  (baud_clk),
    .baud_rate (baud_rate)
`ifdef BAUD_GEN_TICK_EN
    ,
    .baud_tick (baud_tick)
`endif
  );

`ifndef BAUD_GEN_TICK_EN
  assign baud_tick = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // counters and compare helper
  // -------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // -------------------------------------------------------------------------
  // reference model: position inside the current period
  // -------------------------------------------------------------------------
  int         lim_tbl[4] = '{60, 30, 15, 10};
  logic [1:0] m_sel   = 2'b00;
  int         m_pos   = 0;
  bit         m_reset = 1'b1;
  logic       m_tick  = 1'b0;

  function automatic void model_edge(input logic [1:0] s);
    if (m_reset) begin
      m_sel = 2'b00; m_pos = 0; m_tick = 1'b0;
    end else if (s != m_sel) begin
      m_sel = s; m_pos = 0; m_tick = 1'b0;
    end else begin
      m_pos  = (m_pos + 1) % lim_tbl[m_sel];
      m_tick = (m_pos == 0);
    end
  endfunction

  function automatic logic exp_clk();
    return (m_pos >= lim_tbl[m_sel] / 2);
  endfunction

  function automatic logic [16:0] exp_rate();
    return 17'(CLK_HZ / lim_tbl[m_sel]);
  endfunction

  // -------------------------------------------------------------------------
  // scoreboard
  // -------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      chk("baud_clk",  32'(baud_clk),  32'(e[17]));
      chk("baud_rate", 32'(baud_rate), 32'(e[16:0]));
`ifdef BAUD_GEN_TICK_EN
      chk("baud_tick", 32'(baud_tick), 32'(e[18]));
`endif
    end
  end

  // -------------------------------------------------------------------------
  // driver tasks
  // -------------------------------------------------------------------------
  task automatic step(input logic [1:0] s);
    sel = s;
    @(posedge clk);
    model_edge(s);
    exp_q.push_back({m_tick, exp_clk(), exp_rate()});
    #1;
  endtask

  task automatic run(input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) step(s);
  endtask

  task automatic assert_reset_async();
    reset   = 1'b1;
    m_reset = 1'b1;
    m_sel   = 2'b00;
    m_pos   = 0;
    m_tick  = 1'b0;
    #1;
    chk("async_reset_baud_clk",  32'(baud_clk),  32'd0);
    chk("async_reset_baud_rate", 32'(baud_rate), 32'd9600);
`ifdef BAUD_GEN_TICK_EN
    chk("async_reset_baud_tick", 32'(baud_tick), 32'd0);
`endif
  endtask

  // Run with the current select until the model sits on the last count.
  task automatic run_to_last(input logic [1:0] s);
    for (int i = 0; i < 100 && m_pos != lim_tbl[m_sel] - 1; i++) step(s);
  endtask

  // -------------------------------------------------------------------------
  // stimulus
  // -------------------------------------------------------------------------
  initial begin
    logic [1:0] cur;
    reset = 1'b0;
    sel   = 2'b00;
    #3;
    assert_reset_async();
    run(2'b00, 5);
    reset   = 1'b0;
    m_reset = 1'b0;

    // Default rate: rise at edge 30, fall at edge 60, period 60.
    run(2'b00, 130);

    // Mid-period changes through each rate.
    run(2'b01, 70);
    run(2'b10, 50);
    run(2'b11, 35);

    // Select change landing exactly on the wrap edge.
    run_to_last(2'b11);
    step(2'b10);
    run(2'b10, 20);
    run_to_last(2'b10);
    step(2'b00);
    run(2'b00, 10);

    // Asynchronous reset while baud_clk is high, released with sel = 11.
    run(2'b11, 3);
    for (int i = 0; i < 20 && !exp_clk(); i++) step(2'b11);
    @(negedge clk);
    #1;
    chk("baud_clk_high_before_reset", 32'(baud_clk), 32'd1);
    assert_reset_async();
    run(2'b11, 10);
    reset   = 1'b0;
    m_reset = 1'b0;
    run(2'b11, 40);

    // Randomized select changes.
    cur = 2'b11;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) cur = 2'($urandom_range(0, 3));
      step(cur);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the run is bounded well below this.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
